dgldpc_shuffled_cnu: RTL

Serial offset-min-sum check node unit (CNU) for the DG-LDPC shuffled decoder. It is the producer of the check-to-variable messages that the VNU consumes. The block accepts DEG variable-to-check messages, one per cycle, as 10-bit two's complement values. It then emits DEG check-to-variable messages as 6-bit sign-magnitude values in the format expected at the VNU inputs, one per cycle under backpressure.

---
 rtl/dgldpc_pkg.sv | 14 +
 rtl/compl2sm.sv | 25 ++
 rtl/dgldpc_shuffled_cnu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dgldpc_pkg.sv
// Shared widths and state type for the DG-LDPC check node datapath.
package dgldpc_pkg;

  localparam int unsigned VTC_W = 10;
  localparam int unsigned CTV_W = 6;
  localparam int unsigned MAG_W = 5;
  localparam logic [MAG_W-1:0] MAG_MAX = 5'd31;

  typedef enum logic {
    COLLECT,
    EMIT
  } cnu_state_t;

endpackage

// File: rtl/compl2sm.sv
// Two's complement variable-to-check message to saturated 6-bit sign-magnitude.
module compl2sm
  import dgldpc_pkg::*;
(
  input  logic [VTC_W-1:0] vtc,
  output logic [CTV_W-1:0] ctv
);

  logic             sign;
  logic [VTC_W-1:0] mag_full;
  logic [MAG_W-1:0] mag;

  // Absolute value in 10 unsigned bits (-512 becomes 512), then clamp to 31.
  always_comb begin
    sign     = vtc[VTC_W-1];
    mag_full = sign ? (~vtc + 10'd1) : vtc;
    if (|mag_full[VTC_W-1:MAG_W]) begin
      mag = MAG_MAX;
    end else begin
      mag = mag_full[MAG_W-1:0];
    end
    ctv = {sign, mag};
  end

endmodule

// File: rtl/dgldpc_shuffled_cnu.sv
// Serial offset-min-sum check node: collects DEG messages, then emits DEG replies.
module dgldpc_shuffled_cnu
  import dgldpc_pkg::*;
#(
  parameter int unsigned DEG    = 6,
  parameter int unsigned OFFSET = 0,
  localparam int unsigned IDX_W = (DEG > 1) ? $clog2(DEG) : 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [VTC_W-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CTV_W-1:0] o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);
  localparam logic [MAG_W-1:0] OFF      = MAG_W'(OFFSET);

  cnu_state_t       state;
  logic [IDX_W-1:0] in_cnt;
  logic [IDX_W-1:0] out_cnt;
  logic [MAG_W-1:0] min1;
  logic [MAG_W-1:0] min2;
  logic [IDX_W-1:0] idx1;
  logic             par;
  logic [DEG-1:0]   sv;

  logic [CTV_W-1:0] beat_sm;
  logic             beat_s;
  logic [MAG_W-1:0] beat_m;
  logic             accept;

  // Tracking values after folding in the current beat (equal to the registers when idle).
  logic [MAG_W-1:0] upd_min1;
  logic [MAG_W-1:0] upd_min2;
  logic [IDX_W-1:0] upd_idx1;
  logic             upd_par;
  logic [DEG-1:0]   upd_sv;

  // Next message to present: index 0 when leaving COLLECT, else out_cnt+1.
  logic [IDX_W-1:0] sel_k;
  logic [MAG_W-1:0] sel_mag;
  logic [MAG_W-1:0] sel_m;
  logic             sel_s;
  logic [CTV_W-1:0] sel_data;

  compl2sm u_compl2sm (
    .vtc (i_data),
    .ctv (beat_sm)
  );

  assign beat_s  = beat_sm[CTV_W-1];
  assign beat_m  = beat_sm[MAG_W-1:0];
  assign o_ready = (state == COLLECT);
  assign accept  = i_valid && o_ready;

  // Min tracking update and output magnitude/sign selection.
  always_comb begin
    upd_min1 = min1;
    upd_min2 = min2;
    upd_idx1 = idx1;
    upd_par  = par;
    upd_sv   = sv;
    if (accept) begin
      upd_par        = par ^ beat_s;
      upd_sv[in_cnt] = beat_s;
      if (beat_m < min1) begin
        upd_min2 = min1;
        upd_min1 = beat_m;
        upd_idx1 = in_cnt;
      end else if (beat_m < min2) begin
        // Equal-to-min1 lands here too, so a tie makes min2 == min1.
        upd_min2 = beat_m;
      end
    end

    sel_k    = (state == COLLECT) ? '0 : out_cnt + IDX_W'(1);
    sel_mag  = (sel_k == upd_idx1) ? upd_min2 : upd_min1;
    sel_m    = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
    // A zero magnitude carries no sign information; keep it as +0.
    sel_s    = (upd_par ^ upd_sv[sel_k]) && (sel_m != '0);
    sel_data = {sel_s, sel_m};
  end

  // State, counters, min tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= COLLECT;
      in_cnt  <= '0;
      out_cnt <= '0;
      min1    <= MAG_MAX;
      min2    <= MAG_MAX;
      idx1    <= '0;
      par     <= 1'b0;
      sv      <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_idx   <= '0;
      o_last  <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          min1 <= upd_min1;
          min2 <= upd_min2;
          idx1 <= upd_idx1;
          par  <= upd_par;
          sv   <= upd_sv;
          if (accept) begin
            if (in_cnt == LAST_IDX) begin
              state   <= EMIT;
              in_cnt  <= '0;
              out_cnt <= '0;
              o_valid <= 1'b1;
              o_data  <= sel_data;
              o_idx   <= '0;
              o_last  <= 1'b0;
            end else begin
              in_cnt <= in_cnt + IDX_W'(1);
            end
          end
        end
        EMIT: begin
          if (i_ready) begin
            if (o_last) begin
              state   <= COLLECT;
              in_cnt  <= '0;
              out_cnt <= '0;
              min1    <= MAG_MAX;
              min2    <= MAG_MAX;
              idx1    <= '0;
              par     <= 1'b0;
              o_valid <= 1'b0;
              o_data  <= '0;
              o_idx   <= '0;
              o_last  <= 1'b0;
            end else begin
              out_cnt <= sel_k;
              o_data  <= sel_data;
              o_idx   <= sel_k;
              o_last  <= (sel_k == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
